// File: rtl/cdc_rd_ptr_ctrl.sv
// cdc_rd_ptr_ctrl
//   Read-side pointer and flag controller of the asynchronous CDC FIFO.
//   The write domain's Gray pointer is brought in through a plain
//   synchronizer chain and converted to binary. The local read pointer is
//   kept in binary (for the RAM address) and in registered Gray form (for
//   the write domain). Empty, almost-empty and occupancy are registered.
//
// Ports
//   clk          read-domain clock
//   sysRst_n     asynchronous active-low reset
//   syncRst      synchronous flush of the read side (overrides rdReq)
//   wrPtrGray    Gray write pointer from the write clock domain
//   rdReq        request to pop one entry this cycle
//   pop          rdReq accepted; entry at rdAddr is consumed on this edge
//   rdAddr       RAM read address
//   rdPtrGray    registered Gray read pointer towards the write domain
//   empty        registered empty flag
//   almostEmpty  registered, level <= AE_LEVEL
//   level        registered occupancy, 0 .. 2**(n_bits-1)
module cdc_rd_ptr_ctrl #(
  parameter int unsigned n_bits      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AE_LEVEL    = 1
) (
  input  logic              clk,
  input  logic              sysRst_n,
  input  logic              syncRst,
  input  logic [n_bits-1:0] wrPtrGray,
  input  logic              rdReq,
  output logic              pop,
  output logic [n_bits-2:0] rdAddr,
  output logic [n_bits-1:0] rdPtrGray,
  output logic              empty,
  output logic              almostEmpty,
  output logic [n_bits-1:0] level
);

  localparam logic [n_bits-1:0] AE_THRESH = n_bits'(AE_LEVEL);

  logic [n_bits-1:0] r_sync [SYNC_STAGES];
  logic [n_bits-1:0] r_rdBin;
  logic [n_bits-1:0] r_rdPtrGray;
  logic              r_empty;
  logic              r_almostEmpty;
  logic [n_bits-1:0] r_level;

  logic [n_bits-1:0] w_wrGraySync;
  logic [n_bits-1:0] w_wrBinSync;
  logic [n_bits-1:0] w_rdBinInc;
  logic [n_bits-1:0] w_rdBinNext;
  logic [n_bits-1:0] w_rdGrayNext;
  logic [n_bits-1:0] w_levelNext;
  logic              w_pop;

  assign w_wrGraySync = r_sync[SYNC_STAGES-1];

  // Gray to binary: each binary bit is the XOR of all Gray bits from it up to the MSB.
  always_comb begin
    w_wrBinSync = '0;
    for (int unsigned i = 0; i < n_bits; i++) begin
      w_wrBinSync[i] = ^(w_wrGraySync >> i);
    end
  end

  assign w_pop        = rdReq & ~r_empty & ~syncRst;
  assign w_rdBinInc   = r_rdBin + 1'b1;
  assign w_rdBinNext  = w_pop ? w_rdBinInc : r_rdBin;
  assign w_rdGrayNext = w_rdBinNext ^ (w_rdBinNext >> 1);
  // Modular subtraction keeps the level correct across pointer wrap.
  assign w_levelNext  = w_wrBinSync - w_rdBinNext;

  always_ff @(posedge clk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= wrPtrGray;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      r_rdBin       <= '0;
      r_rdPtrGray   <= '0;
      r_empty       <= 1'b1;
      r_almostEmpty <= 1'b1;
      r_level       <= '0;
    end else if (syncRst) begin
      // Flush: jump the read pointer onto the synchronized write pointer.
      r_rdBin       <= w_wrBinSync;
      r_rdPtrGray   <= w_wrGraySync;
      r_empty       <= 1'b1;
      r_almostEmpty <= 1'b1;
      r_level       <= '0;
    end else begin
      r_rdBin       <= w_rdBinNext;
      r_rdPtrGray   <= w_rdGrayNext;
      r_empty       <= (w_wrGraySync == w_rdGrayNext);
      r_almostEmpty <= (w_levelNext <= AE_THRESH);
      r_level       <= w_levelNext;
    end
  end

  assign pop         = w_pop;
  assign rdAddr      = r_rdBin[n_bits-2:0];
  assign rdPtrGray   = r_rdPtrGray;
  assign empty       = r_empty;
  assign almostEmpty = r_almostEmpty;
  assign level       = r_level;

endmodule

// File: tb/tb_cdc_rd_ptr_ctrl.sv
module tb_cdc_rd_ptr_ctrl;

  localparam int NB   = 4;
  localparam int SS   = 2;
  localparam int AE   = 1;
  localparam int DEPTH = 1 << (NB - 1);

  logic          clk = 1'b0;
  logic          sysRst_n;
  logic          syncRst;
  logic [NB-1:0] wrPtrGray;
  logic          rdReq;
  logic          pop;
  logic [NB-2:0] rdAddr;
  logic [NB-1:0] rdPtrGray;
  logic          empty;
  logic          almostEmpty;
  logic [NB-1:0] level;

  cdc_rd_ptr_ctrl #(.n_bits(NB), .SYNC_STAGES(SS), .AE_LEVEL(AE)) dut (
    .clk(clk), .sysRst_n(sysRst_n), .syncRst(syncRst), .wrPtrGray(wrPtrGray),
    .rdReq(rdReq), .pop(pop), .rdAddr(rdAddr), .rdPtrGray(rdPtrGray),
    .empty(empty), .almostEmpty(almostEmpty), .level(level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: unbounded entry counters for writer and reader; the
  // synchronizer is just a delay line of writer counts.
  int wr_total;
  int rd_m;
  int wd [SS];
  int lvl_m;
  bit empty_m;
  bit ae_m;
  bit track_gray;
  logic [NB-1:0] prev_gray;

  function automatic logic [NB-1:0] to_gray(input int cnt);
    int b;
    b = cnt % (1 << NB);
    return NB'(b ^ (b >> 1));
  endfunction

  task automatic model_reset();
    wr_total = 0;
    rd_m     = 0;
    for (int i = 0; i < SS; i++) wd[i] = 0;
    lvl_m    = 0;
    empty_m  = 1;
    ae_m     = 1;
  endtask

  // Called on the falling edge: check registered state, drive inputs,
  // check combinational outputs, advance the model past the next rising edge.
  task automatic cycle(input bit req, input bit flush, input int adv);
    bit pop_e;
    int ws;
    check_eq("empty", int'(empty), int'(empty_m));
    check_eq("almostEmpty", int'(almostEmpty), int'(ae_m));
    check_eq("level", int'(level), lvl_m);
    check_eq("rdPtrGray", int'(rdPtrGray), int'(to_gray(rd_m)));
    check_eq("rdAddr", int'(rdAddr), rd_m % DEPTH);
    if (track_gray)
      check_eq("gray_1bit", int'($countones(prev_gray ^ rdPtrGray) <= 1), 1);
    prev_gray = rdPtrGray;

    wr_total  += adv;
    wrPtrGray  = to_gray(wr_total);
    rdReq      = req;
    syncRst    = flush;
    #1;
    pop_e = req && !empty_m && !flush;
    check_eq("pop", int'(pop), int'(pop_e));

    ws = wd[SS-1];
    if (flush) begin
      rd_m  = ws;
      lvl_m = 0;
    end else begin
      if (pop_e) rd_m++;
      lvl_m = ws - rd_m;
    end
    empty_m = (lvl_m == 0);
    ae_m    = (lvl_m <= AE);
    for (int i = SS - 1; i > 0; i--) wd[i] = wd[i-1];
    wd[0] = wr_total;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    sysRst_n   = 1'b0;
    syncRst    = 1'b0;
    rdReq      = 1'b0;
    wrPtrGray  = '0;
    track_gray = 0;
    prev_gray  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_empty", int'(empty), 1);
    check_eq("rst_ae", int'(almostEmpty), 1);
    check_eq("rst_level", int'(level), 0);
    check_eq("rst_gray", int'(rdPtrGray), 0);
    sysRst_n = 1'b1;

    // Fill: Gray 0->1->3->2 on consecutive edges.
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    check_eq("fill_empty_edge3", int'(empty), 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    check_eq("fill_level3", int'(level), 3);

    // Drain: exactly three pops at addresses 0,1,2, the fourth request refused.
    for (int i = 0; i < 4; i++) begin
      if (i < 3) check_eq("drain_addr", int'(rdAddr), i);
      rdReq = 1'b1;
      #1;
      check_eq("drain_pop", int'(pop), (i < 3) ? 1 : 0);
      cycle(1, 0, 0);
    end
    check_eq("drain_empty", int'(empty), 1);

    // Full, then pop in the same edge a new write pointer arrives.
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1);
    repeat (SS + 1) cycle(0, 0, 0);
    check_eq("full_level", int'(level), DEPTH);
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    check_eq("full_simul_level", int'(level), DEPTH);
    // Drain down to observe almostEmpty at the threshold.
    while (lvl_m > 0) cycle(1, 0, 0);
    cycle(0, 0, 0);

    // Flush at level 5 with rdReq held.
    for (int i = 0; i < 5; i++) cycle(0, 0, 1);
    repeat (SS + 1) cycle(0, 0, 0);
    check_eq("flush_pre_level", int'(level), 5);
    rdReq   = 1'b1;
    syncRst = 1'b1;
    #1;
    check_eq("flush_pop", int'(pop), 0);
    cycle(1, 1, 0);
    check_eq("flush_gray", int'(rdPtrGray), int'(to_gray(wr_total)));
    check_eq("flush_level", int'(level), 0);
    cycle(0, 0, 0);

    // Random traffic across several pointer wraps.
    track_gray = 1;
    prev_gray  = rdPtrGray;
    for (int i = 0; i < 300; i++) begin
      int adv;
      adv = ((wr_total - rd_m) < DEPTH) ? int'($urandom_range(0, 1)) : 0;
      cycle(bit'($urandom_range(0, 2) != 0), 0, adv);
    end
    track_gray = 0;
    check_eq("wrapped", int'(rd_m >= 20), 1);

    // Asynchronous reset in the middle of a pop.
    while (lvl_m == 0) cycle(0, 0, 1);
    rdReq = 1'b1;
    #2;
    sysRst_n = 1'b0;
    #1;
    check_eq("arst_empty", int'(empty), 1);
    check_eq("arst_level", int'(level), 0);
    check_eq("arst_gray", int'(rdPtrGray), 0);
    @(negedge clk);
    model_reset();
    wrPtrGray = '0;
    rdReq     = 1'b0;
    sysRst_n  = 1'b1;
    for (int i = 0; i < 10; i++) cycle(1, 0, (i < 4) ? 1 : 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
